// File: rtl/fft_host_link.sv
// rtl/fft_host_link.sv - host-side sequencer driving the 4-point FFT engine pin interface
//
// Purpose: accepts four sample bytes on a valid/ready stream and replays each one as a
// timed load strobe on the engine's data bus. It then waits for the engine to settle
// and reads back the four packed result bytes with read strobes. Each result is
// unpacked into scaled real/imag values on an output valid/ready stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     sample byte handshake, s_data forwarded to eng_dout
//   m_valid/m_ready     result handshake, m_index bin 0..3, m_real/m_imag = {nibble,4'h0}
//   eng_load, eng_read  load / read strobes to the engine (never high together)
//   eng_dout            sample byte to the engine
//   eng_din             packed result from the engine: [7:4] real, [3:0] imag
//   eng_oe              engine output-enable bus
//   busy                high in every state except IDLE
//   err                 (only with FFT_HOST_OECHK_EN) sticky: engine did not drive its bus
//                       during a read strobe
//
// Optional feature macro: FFT_HOST_OECHK_EN
module fft_host_link #(
    parameter int STROBE_CYC = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_index,
    output logic [7:0] m_real,
    output logic [7:0] m_imag,
    output logic       eng_load,
    output logic       eng_read,
    output logic [7:0] eng_dout,
    input  logic [7:0] eng_din,
    input  logic [7:0] eng_oe,
    output logic       busy
`ifdef FFT_HOST_OECHK_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_SETTLE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_READ_HI,
        ST_READ_LO
    } state_t;

    // Wide enough for 2*STROBE_CYC at the largest legal strobe length.
    localparam logic [4:0] STROBE_LAST = 5'(STROBE_CYC - 1);
    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYC - 1);

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  samp_q;
    logic [1:0]  k_q;
    logic        s_ready_q;
    logic        m_valid_q;
    logic [1:0]  m_index_q;
    logic [7:0]  m_real_q;
    logic [7:0]  m_imag_q;
    logic        eng_load_q;
    logic        eng_read_q;
    logic [7:0]  eng_dout_q;
    logic        accept_d;

    assign accept_d = s_valid && s_ready_q;

`ifdef FFT_HOST_OECHK_EN
    logic seen_q;
    logic err_q;
    logic oe_full_d;

    assign oe_full_d = (eng_oe == 8'hFF);
    assign err       = err_q;
`else
    logic unused_eng_oe;

    assign unused_eng_oe = ^eng_oe;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            samp_q     <= '0;
            k_q        <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_index_q  <= '0;
            m_real_q   <= '0;
            m_imag_q   <= '0;
            eng_load_q <= 1'b0;
            eng_read_q <= 1'b0;
            eng_dout_q <= '0;
`ifdef FFT_HOST_OECHK_EN
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        eng_dout_q <= s_data;
                        s_ready_q  <= 1'b0;
                        state_q    <= ST_SETUP;
                    end else begin
                        s_ready_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    eng_load_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= ST_LOAD_HI;
                end
                ST_LOAD_HI: begin
                    if (cnt_q == STROBE_LAST) begin
                        eng_load_q <= 1'b0;
                        cnt_q      <= '0;
                        samp_q     <= samp_q + 3'd1;
                        // A one-cycle low gap is already its final cycle.
                        s_ready_q  <= (STROBE_CYC == 1) && (samp_q + 3'd1 < 3'd4);
                        state_q    <= ST_LOAD_LO;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_LOAD_LO: begin
                    if (cnt_q != STROBE_LAST) begin
                        cnt_q <= cnt_q + 5'd1;
                        // Open the accept window exactly when the final cycle starts.
                        if (cnt_q + 5'd1 == STROBE_LAST && samp_q < 3'd4) begin
                            s_ready_q <= 1'b1;
                        end
                    end else if (samp_q == 3'd4) begin
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end else if (accept_d) begin
                        // Final cycle stretches until the next byte arrives.
                        eng_dout_q <= s_data;
                        s_ready_q  <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        k_q     <= '0;
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_CAPTURE: begin
                    m_real_q  <= {eng_din[7:4], 4'h0};
                    m_imag_q  <= {eng_din[3:0], 4'h0};
                    m_index_q <= k_q;
                    m_valid_q <= 1'b1;
                    state_q   <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (m_ready) begin
                        m_valid_q  <= 1'b0;
                        eng_read_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_READ_HI;
`ifdef FFT_HOST_OECHK_EN
                        seen_q     <= 1'b0;
`endif
                    end
                end
                ST_READ_HI: begin
`ifdef FFT_HOST_OECHK_EN
                    seen_q <= seen_q | oe_full_d;
`endif
                    if (cnt_q == STROBE_LAST) begin
                        eng_read_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_READ_LO;
`ifdef FFT_HOST_OECHK_EN
                        // Include the last high cycle, which seen_q has not absorbed yet.
                        if (!(seen_q || oe_full_d)) begin
                            err_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_READ_LO: begin
                    if (cnt_q == STROBE_LAST) begin
                        cnt_q <= '0;
                        if (k_q == 2'd3) begin
                            samp_q    <= '0;
                            s_ready_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            k_q     <= k_q + 2'd1;
                            state_q <= ST_CAPTURE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_index  = m_index_q;
    assign m_real   = m_real_q;
    assign m_imag   = m_imag_q;
    assign eng_load = eng_load_q;
    assign eng_read = eng_read_q;
    assign eng_dout = eng_dout_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_host_link.sv
// tb/tb_fft_host_link.sv - self-checking bench for fft_host_link
module tb_fft_host_link;

    localparam int STROBE = 2;
    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_index;
    logic [7:0] m_real;
    logic [7:0] m_imag;
    logic       eng_load;
    logic       eng_read;
    logic [7:0] eng_dout;
    logic [7:0] eng_din;
    logic [7:0] eng_oe;
    logic       busy;
`ifdef FFT_HOST_OECHK_EN
    logic       err;
`endif

    fft_host_link #(.STROBE_CYC(STROBE), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
        .m_real(m_real), .m_imag(m_imag),
        .eng_load(eng_load), .eng_read(eng_read), .eng_dout(eng_dout),
        .eng_din(eng_din), .eng_oe(eng_oe), .busy(busy)
`ifdef FFT_HOST_OECHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: result slot advances on each read strobe rising edge.
    logic [7:0] tbl [4];
    logic [7:0] frame_b [4];
    int rd_cnt = 0;
    int rd_base = 0;
    assign eng_din = tbl[2'(rd_cnt - rd_base)];

    // Bytes the driver got accepted, in order; the monitor matches them to load strobes.
    logic [7:0] acc_bytes [256];
    int acc_wr = 0;
    int acc_cyc = 0;
    int ld_rd = 0;
    int load_falls = 0;
    int lf_base = 0;
    logic err_exp = 1'b0;

    // Pin monitor
    logic prev_load = 1'b0, prev_read = 1'b0;
    int load_w = 0, read_w = 0;
    logic [7:0] dout_hold = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_load = 1'b0;
            prev_read = 1'b0;
            load_w = 0;
            read_w = 0;
            ld_rd = acc_wr;
        end else begin
            if (eng_load || eng_read) check("load_read_excl", 32'(eng_load & eng_read), 0);
            if (eng_load && !prev_load) begin
                check("load_pending", 32'(ld_rd < acc_wr), 1);
                if (ld_rd < acc_wr) begin
                    check("load_data", 32'(eng_dout), 32'(acc_bytes[ld_rd]));
                    ld_rd++;
                end
                dout_hold = eng_dout;
            end
            if (eng_load && prev_load) check("dout_stable", 32'(eng_dout), 32'(dout_hold));
            if (eng_load) load_w++;
            if (!eng_load && prev_load) begin
                check("load_width", load_w, STROBE);
                load_w = 0;
                load_falls++;
            end
            if (eng_read && !prev_read) rd_cnt++;
            if (eng_read) read_w++;
            if (!eng_read && prev_read) begin
                check("read_width", read_w, STROBE);
                read_w = 0;
            end
            if (s_ready) check("s_ready_window", 32'({eng_load, eng_read, m_valid}), 0);
            prev_load = eng_load;
            prev_read = eng_read;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = b;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 200), 1);
        @(negedge clk);
        acc_bytes[acc_wr[7:0]] = b;
        acc_wr++;
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_data = 8'($urandom);
        check("s_ready_drop", 32'(s_ready), 0);
    endtask

    task automatic receive_frame(input int hold_k);
        int n;
        logic [7:0] exp_re, exp_im;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!m_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("m_valid_timeout", 32'(n < 300), 1);
            if (k == 0) check("latency", cyc - acc_cyc, 1 + 2 * STROBE + SETTLE + 1);
            exp_re = 8'(int'(tbl[k]) / 16 * 16);
            exp_im = 8'((int'(tbl[k]) % 16) * 16);
            check("reads_before", rd_cnt - rd_base, k);
            check("m_index", 32'(m_index), k);
            check("m_real", 32'(m_real), 32'(exp_re));
            check("m_imag", 32'(m_imag), 32'(exp_im));
`ifdef FFT_HOST_OECHK_EN
            if (k > 0) err_exp = 1'b1;
            check("err", 32'(err), 32'(err_exp));
`endif
            if (k == hold_k) begin
                m_ready = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    check("hold_stable", {14'd0, m_valid, m_index, m_real, m_imag, eng_read},
                          {14'd0, 1'b1, 2'(k), exp_re, exp_im, 1'b0});
                end
                m_ready = 1'b1;
            end
            @(negedge clk);
            check("m_valid_drop", 32'(m_valid), 0);
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_clear", 32'(busy), 0);
        check("read_count", rd_cnt - rd_base, 4);
        check("load_falls", load_falls - lf_base, 4);
        check("all_loaded", ld_rd, acc_wr);
    endtask

    task automatic run_frame(input int gap, input int hold_k);
        rd_base = rd_cnt;
        lf_base = load_falls;
        for (int i = 0; i < 4; i++) begin
            send_byte(frame_b[i], (i == 0) ? 0 : (gap < 0 ? int'($urandom_range(0, 5)) : gap));
        end
        receive_frame(hold_k);
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < 4; i++) begin
            frame_b[i] = 8'($urandom);
            tbl[i] = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        eng_oe = 8'h00;
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_strobes", 32'({eng_load, eng_read}), 0);
        check("rst_eng_dout", 32'(eng_dout), 0);
        check("rst_m_data", 32'({m_index, m_real, m_imag}), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef FFT_HOST_OECHK_EN
        check("rst_err", 32'(err), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 1);

        // Directed frame: back-to-back bytes, known engine results.
        frame_b[0] = 8'h10; frame_b[1] = 8'h20; frame_b[2] = 8'h30; frame_b[3] = 8'h40;
        tbl[0] = 8'h7F; tbl[1] = 8'h80; tbl[2] = 8'h12; tbl[3] = 8'hF1;
        run_frame(0, -1);

        // Slow producer and a stalled consumer on result 1.
        randomize_frame();
        run_frame(7, 1);

        // Reset during the third load strobe.
        randomize_frame();
        rd_base = rd_cnt;
        for (int i = 0; i < 3; i++) send_byte(frame_b[i], 0);
        n = 0;
        while (!eng_load && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("third_load_seen", 32'(eng_load), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_load", 32'(eng_load), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_s_ready", 32'(s_ready), 0);
`ifdef FFT_HOST_OECHK_EN
        check("rst_mid_err", 32'(err), 0);
        err_exp = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        randomize_frame();
        run_frame(0, -1);

        for (int f = 0; f < 5; f++) begin
            randomize_frame();
            run_frame(-1, int'($urandom_range(0, 4)) - 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_host_link.md
Name: fft_host_link

Overview:
- Host-side sequencer that drives the 4-point FFT engine's pin interface from the other end.
- Accepts four sample bytes on a valid/ready stream and replays each one as a timed load strobe with data on the engine's data bus.
- Waits for the engine to finish processing, then reads the four packed result bytes using read strobes.
- Unpacks each result byte into scaled real/imag values on an output valid/ready stream; used in the FPGA test harness and the bench.

Parameters:
- STROBE_CYC, 2: cycles each strobe is held high; also the low gap after it. Legal range 1..15.
- SETTLE_CYC, 4: idle cycles after the 4th load falls before the first capture. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  sample byte valid
- s_ready  out  1  sample byte accepted this cycle when s_valid && s_ready
- s_data  in  8  sample byte, forwarded unmodified to the engine
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_index  out  2  FFT bin index 0..3 of the current result
- m_real  out  8  signed real part: {nibble, 4'b0}
- m_imag  out  8  signed imag part: {nibble, 4'b0}
- eng_load  out  1  load strobe to the engine, on the engine's ui_in[0]
- eng_read  out  1  read strobe to the engine, on the engine's ui_in[1]
- eng_dout  out  8  sample byte to the engine's uio_in
- eng_din  in  8  packed result from the engine's uio_out: [7:4] real, [3:0] imag
- eng_oe  in  8  engine's uio_oe
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 (s_ready=0, m_valid=0, eng_load=0, eng_read=0, eng_dout=0, m_*=0, busy=0); state IDLE; sample count 0.
- In IDLE, s_ready=1 on the first cycle after reset release.
- States: IDLE, SETUP, LOAD_HI, LOAD_LO, SETTLE, CAPTURE, PRESENT, READ_HI, READ_LO.
- IDLE/LOAD_LO exit accepting a byte:
  - s_ready=1 only in IDLE, and in LOAD_LO on its final cycle when the sample count is below 4.
  - On acceptance, latch s_data into eng_dout and go to SETUP.
- SETUP: 1 cycle, so eng_dout is stable before the strobe rises. Then go to LOAD_HI.
- LOAD_HI: eng_load=1 for STROBE_CYC cycles, then go to LOAD_LO.
- LOAD_LO: eng_load=0 for STROBE_CYC cycles.
  - Increment the sample count on entry.
  - When the count reaches 4, go to SETTLE.
  - Otherwise wait here (s_ready=1) until the next byte is accepted.
- eng_dout holds its value from SETUP through the end of LOAD_LO.
- SETTLE: SETTLE_CYC cycles, then go to CAPTURE with result index k=0.
- CAPTURE: 1 cycle.
  - Register m_real={eng_din[7:4],4'h0}, m_imag={eng_din[3:0],4'h0}, m_index=k.
  - Go to PRESENT.
- PRESENT: m_valid=1 and outputs stable until m_ready. The handshake cycle (m_valid && m_ready) leaves to READ_HI; m_valid drops the next cycle.
- READ_HI: eng_read=1 for STROBE_CYC cycles; this advances the engine's output counter. Then go to READ_LO.
- READ_LO: eng_read=0 for STROBE_CYC cycles, then:
  - if k<3: k++ and go to CAPTURE;
  - if k==3: count=0 and go to IDLE.
- Frame timing: load-to-first-result latency (last byte accept to m_valid) = 1 + 2*STROBE_CYC + SETTLE_CYC + 1 cycles. With defaults this is 10.
- eng_load and eng_read are never high in the same cycle. Both are registered outputs.
- s_valid is ignored outside accepting windows. A byte is never dropped or duplicated.
- m_ready while m_valid=0 has no effect.
- Reset mid-frame: everything returns to reset values immediately, including strobes dropped asynchronously. The partially loaded frame is discarded; the engine must be reset alongside.
- Counters are sized to hold 2*STROBE_CYC. No wrap-around within a state.

Optional Feature:
- Macro FFT_HOST_OECHK_EN.
- When defined:
  - Adds output err (1 bit, reset 0, sticky until rst).
  - During each READ_HI window, latch seen=1 if eng_oe==8'hFF on any cycle.
  - At READ_LO entry, if seen==0, set err=1.
  - seen clears at each READ_HI entry.
- When undefined: no err port, eng_oe unused, no extra logic.

Test Plan:
- Reset, then send bytes 0x10,0x20,0x30,0x40 back-to-back with m_ready=1:
  - eng_dout shows each byte with eng_load high for 2 cycles;
  - four falling edges of eng_load;
  - m_valid is first seen 10 cycles after the 4th accept.
- Engine model returns 0x7F,0x80,0x12,0xF1:
  - results m_index 0..3 are (0x70,0xF0), (0x80,0x00), (0x10,0x20), (0xF0,0x10);
  - exactly 4 read strobes occur, then busy=0.
- s_valid gaps of 7 cycles between bytes: s_ready stays low except in the legal windows; eng_dout never changes while eng_load=1.
- m_ready held low 20 cycles on result 1: m_valid and data stay stable; no read strobe occurs until the handshake.
- Assert rst during the 3rd LOAD_HI: eng_load drops the same cycle; busy=0; the next frame of 4 bytes completes normally.
- With FFT_HOST_OECHK_EN, model never drives eng_oe=0xFF: err=1 after the first READ_LO entry and stays 1 through the frame until rst.
